// File: rtl/logistic_pkg.sv
// Shared Q-format widths, constants, FSM state type and saturation helper
// for the logistic-map oscillator scheduler.
package logistic_pkg;

    localparam int unsigned XW = 16;          // x, t and frequency width (Q0.16)
    localparam int unsigned RW = 18;          // r width (Q2.16)
    localparam int unsigned PW = 2 * RW;      // full product accumulator width
    localparam int unsigned HW = PW - XW;     // product width after >> 16
    localparam int unsigned CW = 5;           // multiplier bit counter width

    localparam logic [XW-1:0] X_SEED_DEFAULT = 16'h4000;
    localparam logic [RW-1:0] R_MAX          = 18'h3FFFF;

    typedef enum logic [2:0] {
        IDLE,
        MUL1,
        MUL2,
        MAP,
        OFFER
    } state_e;

    // Clamp a shifted product to the 16-bit x range.
    function automatic logic [XW-1:0] sat_x(input logic [HW-1:0] p);
        if (|p[HW-1:XW]) return '1;
        return p[XW-1:0];
    endfunction

endpackage

// File: rtl/logistic_sched_if.sv
// Update channel from the scheduler to the oscillator bank (valid/ready).
interface logistic_sched_if
    import logistic_pkg::*;
#(
    parameter int unsigned IDX_W = 2
) ();

    logic             upd_valid;
    logic             upd_ready;
    logic [IDX_W-1:0] upd_idx;
    logic [XW-1:0]    upd_freq;

    modport master (
        output upd_valid,
        output upd_idx,
        output upd_freq,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_idx,
        input  upd_freq,
        output upd_ready
    );

endinterface

// File: rtl/logistic_smul.sv
// Serial shift-add multiplier: one multiplier bit per cycle after start,
// done held high once the last bit is consumed; result delivered >> 16.
module logistic_smul
    import logistic_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [RW-1:0] a_i,
    input  logic [RW-1:0] b_i,
    input  logic [CW-1:0] nbits_i,
    output logic          done_o,
    output logic [HW-1:0] prod_o
);

    logic [PW-1:0] a_q;
    logic [RW-1:0] b_q;
    logic [PW-1:0] acc_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (start_i) begin
            a_q    <= PW'(a_i);
            b_q    <= b_i;
            acc_q  <= '0;
            cnt_q  <= nbits_i;
            done_q <= 1'b0;
        end else if (cnt_q != '0) begin
            if (b_q[0]) acc_q <= acc_q + a_q;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) done_q <= 1'b1;
        end
    end

    assign done_o = done_q;
    assign prod_o = acc_q[PW-1:XW];

endmodule

// File: rtl/logistic_sched.sv
// Logistic-map scheduler: iterates x' = r*x*(1-x) at STEP_HZ and offers the
// mapped frequency to oscillator slots round-robin.
// Optional feature: define LOGISTIC_SCHED_OVERRUN_EN for a sticky overrun output.
module logistic_sched
    import logistic_pkg::*;
#(
    parameter int unsigned   N_OSC   = 4,
    parameter int unsigned   FREQ    = 25_200_000,
    parameter int unsigned   STEP_HZ = 60,
    parameter int unsigned   LO_F    = 200,
    parameter int unsigned   HI_F    = 1200,
    parameter logic [XW-1:0] X_SEED  = X_SEED_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [RW-1:0] r_in,
    logistic_sched_if.master upd
`ifdef LOGISTIC_SCHED_OVERRUN_EN
    ,
    output logic          overrun
`endif
);

    localparam int unsigned DIV = FREQ / STEP_HZ;
    localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW  = (N_OSC > 1) ? $clog2(N_OSC) : 1;

    localparam logic [XW:0]   ONE_Q = 17'h10000;
    localparam logic [XW-1:0] SPAN  = XW'(HI_F - LO_F);
    localparam logic [XW-1:0] LO_Q  = XW'(LO_F);

    state_e        state_q;
    logic [TW-1:0] cnt_q;
    logic          tick_q;
    logic          pend_q;
    logic [XW-1:0] x_q;
    logic [RW-1:0] r_q;
    logic [IW-1:0] idx_q;
    logic          valid_q;
    logic [XW-1:0] freq_q;

    logic          mul_start_c;
    logic [RW-1:0] mul_a_c;
    logic [RW-1:0] mul_b_c;
    logic [CW-1:0] mul_n_c;
    logic [XW-1:0] xp_c;
    logic          mul_done;
    logic [HW-1:0] mul_prod;

    logistic_smul u_smul (
        .clk     (clk),
        .reset   (reset),
        .start_i (mul_start_c),
        .a_i     (mul_a_c),
        .b_i     (mul_b_c),
        .nbits_i (mul_n_c),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    // Multiplier launch and operand select, aligned with each state hand-off.
    always_comb begin
        mul_start_c = 1'b0;
        mul_a_c     = '0;
        mul_b_c     = '0;
        mul_n_c     = '0;
        xp_c        = sat_x(mul_prod);
        case (state_q)
            IDLE: if (tick_q || pend_q) begin
                mul_start_c = 1'b1;
                mul_a_c     = RW'(ONE_Q - {1'b0, x_q});
                mul_b_c     = RW'(x_q);
                mul_n_c     = CW'(XW);
            end
            MUL1: if (mul_done) begin
                mul_start_c = 1'b1;
                mul_a_c     = RW'(mul_prod[XW-1:0]);
                mul_b_c     = r_q;
                mul_n_c     = CW'(RW);
            end
            MUL2: if (mul_done) begin
                mul_start_c = 1'b1;
                mul_a_c     = RW'(SPAN);
                mul_b_c     = RW'(xp_c);
                mul_n_c     = CW'(XW);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            pend_q  <= 1'b0;
            x_q     <= X_SEED;
            r_q     <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            freq_q  <= LO_Q;
        end else begin
            if (cnt_q == TW'(DIV - 1)) begin
                cnt_q  <= '0;
                tick_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_q + TW'(1);
                tick_q <= 1'b0;
            end

            // A tick during an iteration is remembered once; extra ones are lost.
            if (state_q != IDLE && tick_q) pend_q <= 1'b1;

            case (state_q)
                IDLE: if (tick_q || pend_q) begin
                    r_q     <= (r_in >= R_MAX) ? R_MAX : r_in;
                    pend_q  <= 1'b0;
                    state_q <= MUL1;
                end
                MUL1: if (mul_done) state_q <= MUL2;
                MUL2: if (mul_done) begin
                    x_q     <= (xp_c == '0 || xp_c == '1) ? X_SEED : xp_c;
                    state_q <= MAP;
                end
                MAP: if (mul_done) begin
                    freq_q  <= LO_Q + mul_prod[XW-1:0];
                    valid_q <= 1'b1;
                    state_q <= OFFER;
                end
                OFFER: if (upd.upd_ready) begin
                    valid_q <= 1'b0;
                    idx_q   <= (idx_q == IW'(N_OSC - 1)) ? '0 : idx_q + IW'(1);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign upd.upd_valid = valid_q;
    assign upd.upd_idx   = idx_q;
    assign upd.upd_freq  = freq_q;

`ifdef LOGISTIC_SCHED_OVERRUN_EN
    logic overrun_q;

    // Sticky once a tick arrives while one is already pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) overrun_q <= 1'b0;
        else if (state_q != IDLE && tick_q && pend_q) overrun_q <= 1'b1;
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_logistic_sched.sv
// Directed self-checking bench for logistic_sched (tick period 300 cycles);
// also covers the LOGISTIC_SCHED_OVERRUN_EN build.
module tb_logistic_sched;
    import logistic_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [17:0] r_in = 18'h20000;
    int          cyc;
    int          n_checks = 0;
    int          n_fail = 0;
    int          at;

`ifdef LOGISTIC_SCHED_OVERRUN_EN
    logic overrun;
`endif

    always #5 clk = ~clk;

    logistic_sched_if #(.IDX_W(2)) bus ();

    logistic_sched #(
        .N_OSC   (4),
        .FREQ    (18000),
        .STEP_HZ (60),
        .LO_F    (200),
        .HI_F    (1200),
        .X_SEED  (16'h4000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .r_in  (r_in),
        .upd   (bus)
`ifdef LOGISTIC_SCHED_OVERRUN_EN
        ,
        .overrun (overrun)
`endif
    );

    always @(posedge clk or posedge reset)
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input int maxc, output int when);
        when = -1;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk);
            #1;
            if (bus.upd_valid) begin
                when = cyc;
                break;
            end
        end
    endtask

    task automatic check_upd(input string tag, input int lat, input int idx,
                             input int freq, input logic [15:0] x);
        check_eq({tag, "_lat"},  32'(at), 32'(lat));
        check_eq({tag, "_idx"},  32'(bus.upd_idx), 32'(idx));
        check_eq({tag, "_freq"}, 32'(bus.upd_freq), 32'(freq));
        check_eq({tag, "_x"},    32'(dut.x_q), 32'(x));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int          bad;
        logic [1:0]  idx0;
        logic [15:0] f0;

        bus.upd_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(bus.upd_valid), 32'd0);
        check_eq("rst_idx",   32'(bus.upd_idx), 32'd0);
        check_eq("rst_freq",  32'(bus.upd_freq), 32'd200);
        check_eq("rst_x",     32'(dut.x_q), 32'h4000);
        reset = 1'b0;

        // r=2.0 from x=0.25: t=0x3000, x'=0x6000, freq=575
        wait_valid(400, at);
        check_upd("it1", 354, 0, 575, 16'h6000);

        // Hold ready low for 200 cycles; offer must not move.
        bad  = 0;
        idx0 = bus.upd_idx;
        f0   = bus.upd_freq;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (!bus.upd_valid || bus.upd_idx != idx0 || bus.upd_freq != f0) bad++;
        end
        check_eq("stall_stable", 32'(bad), 32'd0);
        bus.upd_ready = 1'b1;
        step_to(555);
        check_eq("xfer1_valid", 32'(bus.upd_valid), 32'd0);
        check_eq("xfer1_idx",   32'(bus.upd_idx), 32'd1);

        // x=0x6000, r=0x22223 drives x' to exactly 0x8000
        r_in = 18'h22223;
        wait_valid(400, at);
        check_upd("it2", 654, 1, 700, 16'h8000);

        // Maximum r from x=0.5 saturates x' to 0xFFFF, so x reseeds
        r_in = 18'h3FFFF;
        wait_valid(400, at);
        check_upd("sat", 954, 2, 1199, 16'h4000);

        // 18'h3FFFF+1 wraps to zero in 18 bits: x'=0 also reseeds
        r_in = 18'h3FFFF + 18'h1;
        wait_valid(400, at);
        check_upd("zero", 1254, 3, 200, 16'h4000);
        step_to(1255);
        check_eq("idx_wrap", 32'(bus.upd_idx), 32'd0);

        // Two ticks while stalled in OFFER: one pending, one dropped
        bus.upd_ready = 1'b0;
        r_in = 18'h20000;
        wait_valid(400, at);
        check_upd("it5", 1554, 0, 575, 16'h6000);
`ifdef LOGISTIC_SCHED_OVERRUN_EN
        check_eq("ovr_clear", 32'(overrun), 32'd0);
`endif
        step_to(2150);
        check_eq("stall2_valid", 32'(bus.upd_valid), 32'd1);
        check_eq("stall2_freq",  32'(bus.upd_freq), 32'd575);
`ifdef LOGISTIC_SCHED_OVERRUN_EN
        check_eq("ovr_set", 32'(overrun), 32'd1);
`endif
        bus.upd_ready = 1'b1;
        step_to(2151);
        check_eq("xfer5_idx", 32'(bus.upd_idx), 32'd1);
        wait_valid(400, at);
        check_upd("pend", 2205, 1, 668, 16'h7800);
        wait_valid(400, at);
        check_upd("it7", 2454, 2, 698, 16'h7F80);
`ifdef LOGISTIC_SCHED_OVERRUN_EN
        check_eq("ovr_sticky", 32'(overrun), 32'd1);
`endif

        // Reset while the second multiply is running
        step_to(2725);
        check_eq("in_mul2", 32'(dut.state_q), 32'(MUL2));
        reset = 1'b1;
        #1;
        check_eq("arst_valid", 32'(bus.upd_valid), 32'd0);
        check_eq("arst_x",     32'(dut.x_q), 32'h4000);
        check_eq("arst_idx",   32'(bus.upd_idx), 32'd0);
        check_eq("arst_freq",  32'(bus.upd_freq), 32'd200);
`ifdef LOGISTIC_SCHED_OVERRUN_EN
        check_eq("arst_ovr", 32'(overrun), 32'd0);
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_valid(400, at);
        check_upd("restart", 354, 0, 575, 16'h6000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
